// File: rtl/complex_pkg.sv
// Shared fixed-point complex types and arithmetic helpers for the FFT datapath.
// Components are signed two's complement; element RE is the leftmost (upper) half of a complex_t.
package complex_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FRAC_WIDTH = 14;

    localparam int RE = 0;
    localparam int IM = 1;

    typedef logic [0:1][DATA_WIDTH-1:0]      complex_t;
    typedef logic signed [2*DATA_WIDTH-1:0]  product_t;

    // Round-half-up requantisation of a full-width product back to a component.
    function automatic logic signed [DATA_WIDTH-1:0] dequant(input product_t p, input int frac);
        product_t r;
        r = (p + (product_t'(1'b1) <<< (frac - 1))) >>> frac;
        return r[DATA_WIDTH-1:0];
    endfunction

    // Clamp a one-bit-wide sum into range; the MSB of the result flags a clamp.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [DATA_WIDTH:0] s);
        logic [DATA_WIDTH:0] r;
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            r = s[DATA_WIDTH] ? {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            r = {1'b0, s[DATA_WIDTH-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Handshake and sample bus between the stage controller, the butterfly and the sample buffers.
// out_overflow exists only when BUTTERFLY_SAT_EN is defined.
interface butterfly_pipe_if #(parameter int DATA_WIDTH = complex_pkg::DATA_WIDTH);

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_inverse;
    logic                       in_scale;
    logic [0:1][DATA_WIDTH-1:0] w;
    logic [0:1][DATA_WIDTH-1:0] in1;
    logic [0:1][DATA_WIDTH-1:0] in2;
    logic                       out_valid;
    logic                       out_ready;
    logic [0:1][DATA_WIDTH-1:0] out1;
    logic [0:1][DATA_WIDTH-1:0] out2;
`ifdef BUTTERFLY_SAT_EN
    logic                       out_overflow;
`endif

    modport master (
`ifdef BUTTERFLY_SAT_EN
        input  out_overflow,
`endif
        output in_valid, in_inverse, in_scale, w, in1, in2, out_ready,
        input  in_ready, out_valid, out1, out2
    );

    modport slave (
`ifdef BUTTERFLY_SAT_EN
        output out_overflow,
`endif
        input  in_valid, in_inverse, in_scale, w, in1, in2, out_ready,
        output in_ready, out_valid, out1, out2
    );

endinterface

// File: rtl/cmul_pipe.sv
// Two-stage complex multiply (S1 capture, S2 full-width products) with conjugate-twiddle select.
// A sideband word rides along so the caller can keep its own operands aligned with the product.
module cmul_pipe
    import complex_pkg::*;
#(
    parameter int FRAC_WIDTH = complex_pkg::FRAC_WIDTH,
    parameter int SIDE_WIDTH = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  valid,
    input  logic                  conj,
    input  complex_t              w,
    input  complex_t              b,
    input  logic [SIDE_WIDTH-1:0] side,
    output logic                  prod_valid,
    output complex_t              prod,
    output logic [SIDE_WIDTH-1:0] prod_side
);

    logic                  s1_valid_r;
    logic                  s1_conj_r;
    complex_t              s1_w_r;
    complex_t              s1_b_r;
    logic [SIDE_WIDTH-1:0] s1_side_r;

    logic                  s2_valid_r;
    logic                  s2_conj_r;
    product_t              s2_rr_r;
    product_t              s2_ii_r;
    product_t              s2_ri_r;
    product_t              s2_ir_r;
    logic [SIDE_WIDTH-1:0] s2_side_r;

    logic signed [DATA_WIDTH-1:0] rr_s;
    logic signed [DATA_WIDTH-1:0] ii_s;
    logic signed [DATA_WIDTH-1:0] ri_s;
    logic signed [DATA_WIDTH-1:0] ir_s;

    // S1 operand capture and S2 product registers, both gated by the global advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_conj_r  <= 1'b0;
            s1_w_r     <= '0;
            s1_b_r     <= '0;
            s1_side_r  <= '0;
            s2_valid_r <= 1'b0;
            s2_conj_r  <= 1'b0;
            s2_rr_r    <= '0;
            s2_ii_r    <= '0;
            s2_ri_r    <= '0;
            s2_ir_r    <= '0;
            s2_side_r  <= '0;
        end else if (enable) begin
            s1_valid_r <= valid;
            s1_conj_r  <= conj;
            s1_w_r     <= w;
            s1_b_r     <= b;
            s1_side_r  <= side;
            s2_valid_r <= s1_valid_r;
            s2_conj_r  <= s1_conj_r;
            s2_rr_r    <= product_t'($signed(s1_w_r[RE])) * product_t'($signed(s1_b_r[RE]));
            s2_ii_r    <= product_t'($signed(s1_w_r[IM])) * product_t'($signed(s1_b_r[IM]));
            s2_ri_r    <= product_t'($signed(s1_w_r[RE])) * product_t'($signed(s1_b_r[IM]));
            s2_ir_r    <= product_t'($signed(s1_w_r[IM])) * product_t'($signed(s1_b_r[RE]));
            s2_side_r  <= s1_side_r;
        end
    end

    // Requantise each product and combine; conj(w) flips the sign of the wi terms.
    always_comb begin
        rr_s = dequant(s2_rr_r, FRAC_WIDTH);
        ii_s = dequant(s2_ii_r, FRAC_WIDTH);
        ri_s = dequant(s2_ri_r, FRAC_WIDTH);
        ir_s = dequant(s2_ir_r, FRAC_WIDTH);
        prod = '0;
        if (s2_conj_r) begin
            prod[RE] = rr_s + ii_s;
            prod[IM] = ri_s - ir_s;
        end else begin
            prod[RE] = rr_s - ii_s;
            prod[IM] = ri_s + ir_s;
        end
    end

    assign prod_valid = s2_valid_r;
    assign prod_side  = s2_side_r;

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: out1 = in1 + w*in2, out2 = in1 - w*in2, three register stages.
// Define BUTTERFLY_SAT_EN for saturating outputs plus out_overflow; otherwise results wrap.
module butterfly_pipe
    import complex_pkg::*;
#(
    parameter int DATA_WIDTH = complex_pkg::DATA_WIDTH,
    parameter int FRAC_WIDTH = complex_pkg::FRAC_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    butterfly_pipe_if.slave   bus
);

    localparam int SIDE_WIDTH = 1 + 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH:0] ROUND_ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

    logic                  adv_s;
    logic                  prod_valid_s;
    complex_t              prod_s;
    logic [SIDE_WIDTH-1:0] prod_side_s;
    complex_t              a_s;
    logic                  scale_s;

    logic signed [DATA_WIDTH:0] sum_s [2];
    logic signed [DATA_WIDTH:0] dif_s [2];
    complex_t                   res1_s;
    complex_t                   res2_s;
    logic                       ovf_s;

    logic     out_valid_r;
    complex_t out1_r;
    complex_t out2_r;
`ifdef BUTTERFLY_SAT_EN
    logic     ovf_r;
    logic [DATA_WIDTH:0] sat1_s [2];
    logic [DATA_WIDTH:0] sat2_s [2];
`endif

    // Every stage moves together; a full output register that is not taken freezes the pipe.
    assign adv_s        = !out_valid_r || bus.out_ready;
    assign bus.in_ready = adv_s;

    cmul_pipe #(
        .FRAC_WIDTH (FRAC_WIDTH),
        .SIDE_WIDTH (SIDE_WIDTH)
    ) u_cmul (
        .clock      (clock),
        .reset      (reset),
        .enable     (adv_s),
        .valid      (bus.in_valid),
        .conj       (bus.in_inverse),
        .w          (bus.w),
        .b          (bus.in2),
        .side       ({bus.in_scale, bus.in1}),
        .prod_valid (prod_valid_s),
        .prod       (prod_s),
        .prod_side  (prod_side_s)
    );

    assign scale_s = prod_side_s[SIDE_WIDTH-1];
    assign a_s     = prod_side_s[SIDE_WIDTH-2:0];

    // S3 arithmetic: widen by one bit, optionally halve with rounding, then reduce.
    always_comb begin
        res1_s = '0;
        res2_s = '0;
        ovf_s  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sum_s[k] = $signed({a_s[k][DATA_WIDTH-1], a_s[k]}) + $signed({prod_s[k][DATA_WIDTH-1], prod_s[k]});
            dif_s[k] = $signed({a_s[k][DATA_WIDTH-1], a_s[k]}) - $signed({prod_s[k][DATA_WIDTH-1], prod_s[k]});
            if (scale_s) begin
                sum_s[k] = (sum_s[k] + ROUND_ONE) >>> 1;
                dif_s[k] = (dif_s[k] + ROUND_ONE) >>> 1;
            end else begin
                sum_s[k] = sum_s[k];
                dif_s[k] = dif_s[k];
            end
`ifdef BUTTERFLY_SAT_EN
            sat1_s[k] = saturate(sum_s[k]);
            sat2_s[k] = saturate(dif_s[k]);
            res1_s[k] = sat1_s[k][DATA_WIDTH-1:0];
            res2_s[k] = sat2_s[k][DATA_WIDTH-1:0];
            ovf_s     = ovf_s | sat1_s[k][DATA_WIDTH] | sat2_s[k][DATA_WIDTH];
`else
            res1_s[k] = sum_s[k][DATA_WIDTH-1:0];
            res2_s[k] = dif_s[k][DATA_WIDTH-1:0];
            ovf_s     = ovf_s | (sum_s[k][DATA_WIDTH] ^ sum_s[k][DATA_WIDTH-1])
                              | (dif_s[k][DATA_WIDTH] ^ dif_s[k][DATA_WIDTH-1]);
`endif
        end
    end

    // S3 output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out1_r      <= '0;
            out2_r      <= '0;
`ifdef BUTTERFLY_SAT_EN
            ovf_r       <= 1'b0;
`endif
        end else if (adv_s) begin
            out_valid_r <= prod_valid_s;
            out1_r      <= res1_s;
            out2_r      <= res2_s;
`ifdef BUTTERFLY_SAT_EN
            ovf_r       <= ovf_s && prod_valid_s;
`endif
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out1      = out1_r;
    assign bus.out2      = out2_r;
`ifdef BUTTERFLY_SAT_EN
    assign bus.out_overflow = ovf_r;
`else
    // Wrap mode has no overflow port; the flag is only a local observation point.
    logic ovf_unused_s;
    assign ovf_unused_s = ovf_s;
`endif

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Pipelined, handshaked radix-2 DIT butterfly for the streaming FFT datapath.
- Computes out1 = in1 + w·in2 and out2 = in1 − w·in2 on fixed-point complex samples.
- Per-transaction controls select inverse transform (conjugated twiddle) and per-stage 1/2 scaling.
- Sits between the FFT stage controller/twiddle ROM and the inter-stage sample buffers; accepts one butterfly per cycle with full backpressure.

Parameters:
- DATA_WIDTH, 32, bit width of each real/imag component (signed two's complement).
- FRAC_WIDTH, 14, fractional bits of all operands; 1.0 = 2^FRAC_WIDTH.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_inverse  in  1  1 = use conj(w) (IFFT).
- in_scale  in  1  1 = divide both outputs by 2 with rounding.
- w  in  2×DATA_WIDTH  twiddle, packed [0:1], index RE/IM.
- in1  in  2×DATA_WIDTH  top input sample.
- in2  in  2×DATA_WIDTH  bottom input sample.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts output.
- out1  out  2×DATA_WIDTH  top result.
- out2  out  2×DATA_WIDTH  bottom result.

Behaviour:
- Reset: all stage valids, out_valid, out1 and out2 are 0. in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation drops all in-flight transactions; no stale output appears after release.
- Pipeline has 3 register stages (S1 input capture, S2 products, S3 add/sub/scale). Latency is 3 cycles from accept to out_valid, with no stalls.
- Global advance: adv = !out_valid | out_ready.
- in_ready = adv (combinational). An input is accepted when in_valid & in_ready.
- All stages (data and valid) shift only when adv = 1. When adv = 0, all stages hold and out1/out2 stay stable.
- Throughput is 1 butterfly per cycle when out_ready stays high. Bubbles (in_valid = 0) propagate as invalid stages.
- in_inverse and in_scale are captured with the data in S1 and travel with the transaction.
- S2 products are full 2×DATA_WIDTH signed.
- Each product is dequantised by round-half-up: (p + 2^(FRAC_WIDTH−1)) >>> FRAC_WIDTH, truncated to DATA_WIDTH.
- Forward mode: v_re = dq(wr·br) − dq(wi·bi); v_im = dq(wr·bi) + dq(wi·br).
- Inverse mode: v_re = dq(wr·br) + dq(wi·bi); v_im = dq(wr·bi) − dq(wi·br).
- S3 computes sums/differences in DATA_WIDTH+1 bits. If scale is set: (s + 1) >>> 1. The result is then reduced to DATA_WIDTH, by wrap or saturation (see below).
- Simultaneous accept and output handshake in the same cycle is legal and is required for full throughput.

Optional Feature:
- Macro BUTTERFLY_SAT_EN.
- Defined: S3 results outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] clamp to the nearest bound.
- Defined: adds output port out_overflow (1 bit), high with out_valid when any of the four components clamped; reset value 0.
- Undefined: two's-complement wrap and no out_overflow port.

Decomposition:
- complex_pkg holds: RE = 0 / IM = 1 index constants; the complex_t typedef (packed [0:1][DATA_WIDTH−1:0]) parametrised via a localparam default; and the dequant and saturate helper functions.
- One sub-module, cmul_pipe: the S1–S2 complex multiply with conjugate select, reused by future radix-4 work.
- The add/sub/scale stage stays inline in butterfly_pipe.

Test Plan:
- Identity twiddle: w=(16384,0), in1=(100,200), in2=(30,−40), out_ready=1 → after 3 cycles out1=(130,160), out2=(70,240).
- Twiddle j: w=(0,16384), same in1/in2 → out1=(140,230), out2=(60,170). Same inputs with in_inverse=1 → out1=(60,170), out2=(140,230).
- Scale: identity-twiddle vector with in_scale=1 → out1=(65,80), out2=(35,120).
- Backpressure: stream 5 back-to-back vectors, drop out_ready for 4 cycles once out_valid is high → in_ready=0 during the stall, out1/out2 held constant, all 5 results delivered in order with none lost or duplicated.
- Reset mid-stream: assert reset for 1 cycle with 3 transactions in flight → out_valid=0 the next cycle, no output until new input plus 3 cycles.
- Overflow: w=(16384,0), in1=(2^31−1,0), in2=(10,0) → BUTTERFLY_SAT_EN defined: out1_re=2^31−1, out_overflow=1. Undefined: out1_re=−2^31+9.
